// File: rtl/multicycle_cpu_if.sv
// Instruction and data memory bus of the multicycle CPU.
// The master side is the CPU core; the slave side is the memory system.
interface multicycle_cpu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] imem_addr;
    logic [31:0]      imem_rdata;
    logic [WIDTH-1:0] dmem_addr;
    logic [WIDTH-1:0] dmem_wdata;
    logic             dmem_we;
    logic             dmem_re;
    logic [WIDTH-1:0] dmem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output dmem_addr,
        output dmem_wdata,
        output dmem_we,
        output dmem_re,
        input  dmem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_we,
        input  dmem_re,
        output dmem_rdata
    );
endinterface

// File: rtl/multicycle_cpu.sv
// Multicycle RV32I-subset core: ADDI, ADD, SUB, LUI, LW, SW, BEQ, BNE.
//
// state  | meaning
// FETCH  | latch instruction word into IR
// DECODE | read operands into A/B, latch immediate, trap on illegal encoding
// EXEC   | ALU/address computation, branch resolution
// MEM    | one-cycle load or store strobe
// WB     | register write-back, PC advance
// TRAP   | frozen until reset, illegal flag set
module multicycle_cpu #(
    parameter int               WIDTH    = 32,
    parameter int               NREGS    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_cpu_if.master  bus,
    output logic [WIDTH-1:0]  a0,
    output logic              illegal,
    output logic [31:0]       instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam int               RIDX    = $clog2(NREGS);
    localparam logic [5:0]       NREGS_L = 6'(NREGS);
    localparam logic [WIDTH-1:0] FOUR    = WIDTH'(4);

    state_t           state;
    logic [31:0]      ir;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] aluout;
    logic [WIDTH-1:0] regs [NREGS];
    logic             we_q;
    logic             re_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    logic is_addi, is_add, is_sub, is_lui, is_lw, is_sw, is_beq, is_bne;
    logic legal, bad_idx;
    logic uses_rs1, uses_rs2, uses_rd;

    logic [WIDTH-1:0] imm_dec;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] br_target;
    logic             br_taken;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rd     = ir[11:7];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];

    // Instruction classification and register index range checks.
    always_comb begin
        is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
        is_add   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
        is_sub   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
        is_lui   = (opcode == 7'b0110111);
        is_lw    = (opcode == 7'b0000011) && (funct3 == 3'b010);
        is_sw    = (opcode == 7'b0100011) && (funct3 == 3'b010);
        is_beq   = (opcode == 7'b1100011) && (funct3 == 3'b000);
        is_bne   = (opcode == 7'b1100011) && (funct3 == 3'b001);
        legal    = is_addi | is_add | is_sub | is_lui | is_lw | is_sw | is_beq | is_bne;
        uses_rs1 = is_addi | is_add | is_sub | is_lw | is_sw | is_beq | is_bne;
        uses_rs2 = is_add | is_sub | is_sw | is_beq | is_bne;
        uses_rd  = is_addi | is_add | is_sub | is_lui | is_lw;
        // Only fields that are actually register indices for this format are checked.
        bad_idx  = (uses_rs1 && ({1'b0, rs1} >= NREGS_L)) ||
                   (uses_rs2 && ({1'b0, rs2} >= NREGS_L)) ||
                   (uses_rd  && ({1'b0, rd}  >= NREGS_L));
    end

    // Immediate selection; every format sign-extends from instruction bit 31.
    always_comb begin
        imm_dec = WIDTH'($signed(ir[31:20]));
        if (is_sw)
            imm_dec = WIDTH'($signed({ir[31:25], ir[11:7]}));
        else if (is_beq || is_bne)
            imm_dec = WIDTH'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
        else if (is_lui)
            imm_dec = WIDTH'($signed({ir[31:12], 12'b0}));
    end

    // Register file read ports; x0 is hard-wired to zero.
    always_comb begin
        rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1[RIDX-1:0]];
        rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2[RIDX-1:0]];
    end

    // ALU result for EXEC and branch resolution.
    always_comb begin
        alu_res = a + imm;
        if (is_add)
            alu_res = a + b;
        else if (is_sub)
            alu_res = a - b;
        else if (is_lui)
            alu_res = imm;
        pc_plus4  = pc + FOUR;
        br_target = pc + imm;
        br_taken  = is_beq ? (a == b) : (a != b);
    end

    // Main sequencer: state, datapath registers, register file and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            aluout  <= '0;
            instret <= '0;
            illegal <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= bus.imem_rdata;
                    state <= DECODE;
                end
                DECODE: begin
                    a   <= rs1_val;
                    b   <= rs2_val;
                    imm <= imm_dec;
                    if (!legal || bad_idx) begin
                        illegal <= 1'b1;
                        state   <= TRAP;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_beq || is_bne) begin
                        // A misaligned taken target traps with the branch's own PC kept.
                        if (br_taken && br_target[1]) begin
                            illegal <= 1'b1;
                            state   <= TRAP;
                        end else begin
                            pc      <= br_taken ? br_target : pc_plus4;
                            instret <= instret + 32'd1;
                            state   <= FETCH;
                        end
                    end else begin
                        aluout <= alu_res;
                        if (is_lw || is_sw) begin
                            we_q  <= is_sw;
                            re_q  <= is_lw;
                            state <= MEM;
                        end else begin
                            state <= WB;
                        end
                    end
                end
                MEM: begin
                    we_q <= 1'b0;
                    re_q <= 1'b0;
                    if (is_sw) begin
                        pc      <= pc_plus4;
                        instret <= instret + 32'd1;
                        state   <= FETCH;
                    end else begin
                        state <= WB;
                    end
                end
                WB: begin
                    if (rd != 5'd0)
                        regs[rd[RIDX-1:0]] <= is_lw ? bus.dmem_rdata : aluout;
                    pc      <= pc_plus4;
                    instret <= instret + 32'd1;
                    state   <= FETCH;
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign bus.imem_addr  = pc;
    assign bus.dmem_addr  = aluout;
    assign bus.dmem_wdata = b;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_re    = re_q;
    assign a0             = regs[10];

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: a 32-bit core plus a 16-bit core with
// 16 registers and a non-zero reset PC, each with its own memory models.
module tb_multicycle_cpu;

    logic clk;
    logic rst;

    logic [31:0] a0_32;
    logic        ill32;
    logic [31:0] ret32;
    logic [15:0] a0_16;
    logic        ill16;
    logic [31:0] ret16;

    logic [31:0] imem32 [64];
    logic [31:0] imem16 [256];
    logic [31:0] dmem32 [64];

    int tests;
    int fails;
    int we_cnt;
    int re_cnt;
    int both_cnt;

    multicycle_cpu_if #(.WIDTH(32)) bus32 ();
    multicycle_cpu_if #(.WIDTH(16)) bus16 ();

    multicycle_cpu #(.WIDTH(32), .NREGS(32), .RESET_PC(32'h0)) dut32 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus32),
        .a0      (a0_32),
        .illegal (ill32),
        .instret (ret32)
    );

    multicycle_cpu #(.WIDTH(16), .NREGS(16), .RESET_PC(16'h0100)) dut16 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus16),
        .a0      (a0_16),
        .illegal (ill16),
        .instret (ret16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus32.imem_rdata = imem32[bus32.imem_addr[7:2]];
    assign bus16.imem_rdata = imem16[bus16.imem_addr[9:2]];
    assign bus16.dmem_rdata = '0;

    // Data memory: write on the strobe edge, read data valid the following cycle.
    always @(posedge clk) begin
        if (bus32.dmem_we)
            dmem32[bus32.dmem_addr[7:2]] <= bus32.dmem_wdata;
        if (bus32.dmem_re)
            bus32.dmem_rdata <= dmem32[bus32.dmem_addr[7:2]];
    end

    // Strobe monitor for the 32-bit core.
    always @(negedge clk) begin
        if (bus32.dmem_we) we_cnt++;
        if (bus32.dmem_re) re_cnt++;
        if (bus32.dmem_we && bus32.dmem_re) both_cnt++;
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            imem32[i] = 32'h0;
            dmem32[i] = 32'h0;
        end
        for (int i = 0; i < 256; i++)
            imem16[i] = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        we_cnt   = 0;
        re_cnt   = 0;
        both_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (bus32.imem_addr !== 32'h0) begin fails++; $display("FAIL reset_pc32: got %h exp %h", bus32.imem_addr, 32'h0); end
        tests++; if (bus16.imem_addr !== 16'h0100) begin fails++; $display("FAIL reset_pc16: got %h exp %h", bus16.imem_addr, 16'h0100); end
        tests++; if (bus32.dmem_we !== 1'b0 || bus32.dmem_re !== 1'b0) begin fails++; $display("FAIL reset_strobes: we %b re %b exp 0 0", bus32.dmem_we, bus32.dmem_re); end
        tests++; if (a0_32 !== 32'h0) begin fails++; $display("FAIL reset_a0: got %h exp 0", a0_32); end
        tests++; if (ill32 !== 1'b0 || ret32 !== 32'h0) begin fails++; $display("FAIL reset_flags: illegal %b instret %0d exp 0 0", ill32, ret32); end
        rst = 1'b0;
    endtask

    task automatic test_addi_x0();
        clear_mem();
        imem32[0] = 32'h00500513;   // ADDI x10,x0,5
        imem32[1] = 32'h00700013;   // ADDI x0,x0,7
        imem32[2] = 32'h00050533;   // ADD  x10,x10,x0
        do_reset();
        repeat (3) @(negedge clk);
        tests++; if (a0_32 !== 32'h0) begin fails++; $display("FAIL addi_early: got %h exp 0", a0_32); end
        @(negedge clk);
        tests++; if (a0_32 !== 32'd5) begin fails++; $display("FAIL addi_a0: got %h exp 5", a0_32); end
        repeat (4) @(negedge clk);
        tests++; if (ret32 !== 32'd2) begin fails++; $display("FAIL addi_instret: got %0d exp 2", ret32); end
        tests++; if (bus32.imem_addr !== 32'd8) begin fails++; $display("FAIL addi_pc: got %h exp 8", bus32.imem_addr); end
        repeat (4) @(negedge clk);
        tests++; if (a0_32 !== 32'd5) begin fails++; $display("FAIL x0_zero: a0 got %h exp 5", a0_32); end
    endtask

    task automatic test_width16();
        clear_mem();
        imem16[64] = 32'hFFF00513;  // ADDI x10,x0,-1
        imem16[65] = 32'h00A50533;  // ADD  x10,x10,x10
        imem16[66] = 32'h00100A13;  // ADDI x20,x0,1 (rd beyond 16 registers)
        do_reset();
        repeat (4) @(negedge clk);
        tests++; if (a0_16 !== 16'hFFFF) begin fails++; $display("FAIL w16_neg1: got %h exp ffff", a0_16); end
        repeat (4) @(negedge clk);
        tests++; if (a0_16 !== 16'hFFFE) begin fails++; $display("FAIL w16_add: got %h exp fffe", a0_16); end
        tests++; if (bus16.imem_addr !== 16'h0108) begin fails++; $display("FAIL w16_pc: got %h exp 0108", bus16.imem_addr); end
        repeat (2) @(negedge clk);
        tests++; if (ill16 !== 1'b1) begin fails++; $display("FAIL w16_idx_trap: illegal %b exp 1", ill16); end
        tests++; if (bus16.imem_addr !== 16'h0108 || ret16 !== 32'd2) begin fails++; $display("FAIL w16_trap_hold: pc %h instret %0d exp 0108 2", bus16.imem_addr, ret16); end
    endtask

    task automatic test_alu_lui();
        clear_mem();
        imem32[0] = 32'h80000537;   // LUI  x10,0x80000
        imem32[1] = 32'h00100593;   // ADDI x11,x0,1
        imem32[2] = 32'h40B50533;   // SUB  x10,x10,x11
        do_reset();
        repeat (4) @(negedge clk);
        tests++; if (a0_32 !== 32'h80000000) begin fails++; $display("FAIL lui: got %h exp 80000000", a0_32); end
        repeat (8) @(negedge clk);
        tests++; if (a0_32 !== 32'h7FFFFFFF) begin fails++; $display("FAIL sub: got %h exp 7fffffff", a0_32); end
    endtask

    task automatic test_load_store();
        clear_mem();
        imem32[0] = 32'h00900513;   // ADDI x10,x0,9
        imem32[1] = 32'h00A02423;   // SW   x10,8(x0)
        imem32[2] = 32'h00802583;   // LW   x11,8(x0)
        imem32[3] = 32'h00B58533;   // ADD  x10,x11,x11
        do_reset();
        repeat (7) @(negedge clk);
        tests++; if (bus32.dmem_we !== 1'b1 || bus32.dmem_addr !== 32'd8 || bus32.dmem_wdata !== 32'd9) begin fails++; $display("FAIL sw_strobe: we %b addr %h wdata %h exp 1 8 9", bus32.dmem_we, bus32.dmem_addr, bus32.dmem_wdata); end
        @(negedge clk);
        tests++; if (bus32.dmem_we !== 1'b0 || ret32 !== 32'd2) begin fails++; $display("FAIL sw_done: we %b instret %0d exp 0 2", bus32.dmem_we, ret32); end
        repeat (3) @(negedge clk);
        tests++; if (bus32.dmem_re !== 1'b1 || bus32.dmem_addr !== 32'd8) begin fails++; $display("FAIL lw_strobe: re %b addr %h exp 1 8", bus32.dmem_re, bus32.dmem_addr); end
        @(negedge clk);
        tests++; if (ret32 !== 32'd2) begin fails++; $display("FAIL lw_not_early: instret %0d exp 2", ret32); end
        @(negedge clk);
        tests++; if (ret32 !== 32'd3) begin fails++; $display("FAIL lw_latency: instret %0d exp 3", ret32); end
        repeat (4) @(negedge clk);
        tests++; if (a0_32 !== 32'd18) begin fails++; $display("FAIL lw_data: a0 got %0d exp 18", a0_32); end
        tests++; if (we_cnt !== 1 || re_cnt !== 1 || both_cnt !== 0) begin fails++; $display("FAIL strobe_count: we %0d re %0d both %0d exp 1 1 0", we_cnt, re_cnt, both_cnt); end
        tests++; if (dmem32[2] !== 32'd9) begin fails++; $display("FAIL mem_word: got %h exp 9", dmem32[2]); end
    endtask

    task automatic test_branch_loop();
        clear_mem();
        imem32[0] = 32'h00300513;   // ADDI x10,x0,3
        imem32[1] = 32'hFFF50513;   // ADDI x10,x10,-1
        imem32[2] = 32'hFE051EE3;   // BNE  x10,x0,-4
        do_reset();
        repeat (8) @(negedge clk);
        tests++; if (a0_32 !== 32'd2) begin fails++; $display("FAIL loop_first: a0 %0d exp 2", a0_32); end
        repeat (3) @(negedge clk);
        tests++; if (bus32.imem_addr !== 32'd4) begin fails++; $display("FAIL bne_taken: pc %h exp 4", bus32.imem_addr); end
        repeat (13) @(negedge clk);
        tests++; if (bus32.imem_addr !== 32'd8 || ret32 !== 32'd6) begin fails++; $display("FAIL loop_pre_exit: pc %h instret %0d exp 8 6", bus32.imem_addr, ret32); end
        @(negedge clk);
        tests++; if (a0_32 !== 32'd0 || ret32 !== 32'd7) begin fails++; $display("FAIL loop_exit: a0 %0d instret %0d exp 0 7", a0_32, ret32); end
        tests++; if (bus32.imem_addr !== 32'd12 || ill32 !== 1'b0) begin fails++; $display("FAIL loop_pc: pc %h illegal %b exp c 0", bus32.imem_addr, ill32); end
    endtask

    task automatic test_branch_trap();
        clear_mem();
        imem32[0] = 32'h00100513;   // ADDI x10,x0,1
        imem32[1] = 32'h00050463;   // BEQ  x10,x0,+8 (not taken)
        imem32[2] = 32'h00000163;   // BEQ  x0,x0,+2  (misaligned)
        do_reset();
        repeat (7) @(negedge clk);
        tests++; if (bus32.imem_addr !== 32'd8 || ret32 !== 32'd2) begin fails++; $display("FAIL beq_not_taken: pc %h instret %0d exp 8 2", bus32.imem_addr, ret32); end
        repeat (3) @(negedge clk);
        tests++; if (ill32 !== 1'b1) begin fails++; $display("FAIL misalign_trap: illegal %b exp 1", ill32); end
        tests++; if (bus32.imem_addr !== 32'd8 || ret32 !== 32'd2) begin fails++; $display("FAIL misalign_hold: pc %h instret %0d exp 8 2", bus32.imem_addr, ret32); end
    endtask

    task automatic test_illegal();
        clear_mem();
        imem32[0] = 32'h00500513;   // ADDI x10,x0,5
        imem32[1] = 32'h00000000;   // illegal
        do_reset();
        repeat (5) @(negedge clk);
        tests++; if (ill32 !== 1'b0) begin fails++; $display("FAIL illegal_early: got %b exp 0", ill32); end
        @(negedge clk);
        tests++; if (ill32 !== 1'b1) begin fails++; $display("FAIL illegal_set: got %b exp 1", ill32); end
        repeat (10) @(negedge clk);
        tests++; if (bus32.imem_addr !== 32'd4 || ret32 !== 32'd1 || a0_32 !== 32'd5) begin fails++; $display("FAIL trap_frozen: pc %h instret %0d a0 %0d exp 4 1 5", bus32.imem_addr, ret32, a0_32); end
        tests++; if (we_cnt !== 0 || re_cnt !== 0 || ill32 !== 1'b1) begin fails++; $display("FAIL trap_quiet: we %0d re %0d illegal %b exp 0 0 1", we_cnt, re_cnt, ill32); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (ill32 !== 1'b0 || bus32.imem_addr !== 32'h0 || a0_32 !== 32'h0) begin fails++; $display("FAIL trap_reset: illegal %b pc %h a0 %h exp 0 0 0", ill32, bus32.imem_addr, a0_32); end
    endtask

    task automatic test_reset_in_mem();
        clear_mem();
        imem32[0] = 32'h00900513;   // ADDI x10,x0,9
        imem32[1] = 32'h00A02423;   // SW   x10,8(x0)
        do_reset();
        repeat (7) @(negedge clk);
        tests++; if (bus32.dmem_we !== 1'b1 || ret32 !== 32'd1) begin fails++; $display("FAIL mem_state: we %b instret %0d exp 1 1", bus32.dmem_we, ret32); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (bus32.dmem_we !== 1'b0 || bus32.imem_addr !== 32'h0) begin fails++; $display("FAIL mem_reset: we %b pc %h exp 0 0", bus32.dmem_we, bus32.imem_addr); end
        tests++; if (ret32 !== 32'd0 || a0_32 !== 32'd0) begin fails++; $display("FAIL mem_reset_regs: instret %0d a0 %h exp 0 0", ret32, a0_32); end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        we_cnt   = 0;
        re_cnt   = 0;
        both_cnt = 0;
        rst      = 1'b1;
        clear_mem();
        test_reset();
        test_addi_x0();
        test_width16();
        test_alu_lui();
        test_load_store();
        test_branch_loop();
        test_branch_trap();
        test_illegal();
        test_reset_in_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
